// File: rtl/la_pkg.sv
`default_nettype none
// ============================================================================
// Module      : la_pkg
// Description : Shared types and constants for the transmit arbiter.
//               owner_t    - current transmit grant
//               tx_state_t - arbiter sequencing states
//               ID_STRING  - fixed identification string, byte 0 sent first
// Revision    : 1.0 - initial release
// ============================================================================
package la_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_ID   = 2'd1,
    OWN_META = 2'd2,
    OWN_DATA = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GUARD = 2'd2,
    ST_DRAIN = 2'd3
  } tx_state_t;

  // Index 0 is the leftmost element, so the string goes out as "1ALS".
  localparam logic [0:3][7:0] ID_STRING = {8'h31, 8'h41, 8'h4C, 8'h53};
  localparam logic [1:0]      ID_LAST   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/tx_arbiter_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : word_serializer
// Description : Holds the current sample word and the byte index of the
//               packet in flight, and selects the little-endian byte to send.
// Ports       : clock, ext_reset_n (async), soft_reset_n (sync)
//               bidx_clear / bidx_incr - byte index control
//               word_load              - capture data_word into word_reg
//               data_word              - incoming sample word
//               bidx                   - current byte index (also used for ID)
//               byte_out               - selected sample byte
// Revision    : 1.0 - initial release
// ============================================================================
module word_serializer #(
  parameter int SAMPLE_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    ext_reset_n,
  input  logic                    soft_reset_n,
  input  logic                    bidx_clear,
  input  logic                    bidx_incr,
  input  logic                    word_load,
  input  logic [SAMPLE_WIDTH-1:0] data_word,
  output logic [1:0]              bidx,
  output logic [7:0]              byte_out
);

  logic [SAMPLE_WIDTH-1:0] word_reg;
  logic [31:0]             padded;

  always_ff @(posedge clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      word_reg <= '0;
      bidx     <= 2'd0;
    end else if (!soft_reset_n) begin
      word_reg <= '0;
      bidx     <= 2'd0;
    end else begin
      if (word_load) begin
        word_reg <= data_word;
      end
      if (bidx_clear) begin
        bidx <= 2'd0;
      end else if (bidx_incr) begin
        bidx <= bidx + 2'd1;
      end
    end
  end

  // Byte 0 is sent in the same cycle the word is accepted, before word_reg
  // has been loaded, so it comes straight from data_word. Unused upper bits
  // stay zero, which pads the top byte of non-multiple-of-8 widths.
  always_comb begin
    padded = '0;
    if (bidx == 2'd0) begin
      padded[SAMPLE_WIDTH-1:0] = data_word;
    end else begin
      padded[SAMPLE_WIDTH-1:0] = word_reg;
    end
    byte_out = padded[{bidx, 3'b000} +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tx_arbiter
// Description : Shares one UART transmitter between the ID responder, the
//               metadata stream and the sample readout path. Fixed priority
//               ID > META > DATA, grant held for a whole packet.
// Ports       : clock, ext_reset_n (async low), soft_reset_n (sync low)
//               send_id                              - ID request pulse
//               meta_valid/meta_data/meta_last       - metadata byte stream
//               meta_ready                           - meta byte consumed
//               data_valid/data_word/data_last       - sample word stream
//               data_ready                           - sample word consumed
//               tx_busy, tx_start, tx_data           - UART interface
//               owner                                - 0 none,1 ID,2 META,3 DATA
//               busy                                 - grant held or ID pending
// Revision    : 1.0 - initial release
// ============================================================================
module tx_arbiter
  import la_pkg::*;
#(
  parameter  int SAMPLE_WIDTH = 8,
  localparam int NBYTES       = (SAMPLE_WIDTH + 7) / 8
) (
  input  logic                    clock,
  input  logic                    ext_reset_n,
  input  logic                    soft_reset_n,
  input  logic                    send_id,
  input  logic                    meta_valid,
  input  logic [7:0]              meta_data,
  input  logic                    meta_last,
  output logic                    meta_ready,
  input  logic                    data_valid,
  input  logic [SAMPLE_WIDTH-1:0] data_word,
  input  logic                    data_last,
  output logic                    data_ready,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  output logic [1:0]              owner,
  output logic                    busy
);

  localparam logic [1:0] DATA_LAST_BIDX = 2'(NBYTES - 1);

  tx_state_t  state, state_next;
  owner_t     grant, grant_next;
  logic       id_pending, id_pending_next;
  logic       last_flag, last_flag_next;

  logic       bidx_clear, bidx_incr, word_load;
  logic [1:0] bidx;
  logic [7:0] sample_byte;
  logic       src_ok;
  logic [7:0] src_byte;

  word_serializer #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_serializer (
    .clock        (clock),
    .ext_reset_n  (ext_reset_n),
    .soft_reset_n (soft_reset_n),
    .bidx_clear   (bidx_clear),
    .bidx_incr    (bidx_incr),
    .word_load    (word_load),
    .data_word    (data_word),
    .bidx         (bidx),
    .byte_out     (sample_byte)
  );

  always_ff @(posedge clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state      <= ST_IDLE;
      grant      <= OWN_NONE;
      id_pending <= 1'b0;
      last_flag  <= 1'b0;
    end else if (!soft_reset_n) begin
      state      <= ST_IDLE;
      grant      <= OWN_NONE;
      id_pending <= 1'b0;
      last_flag  <= 1'b0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      id_pending <= id_pending_next;
      last_flag  <= last_flag_next;
    end
  end

  // Byte availability for the current owner. A DATA word is only needed at
  // the start of a word; later bytes come from the stored copy.
  always_comb begin
    src_ok   = 1'b0;
    src_byte = 8'h00;
    unique case (grant)
      OWN_ID: begin
        src_ok   = 1'b1;
        src_byte = ID_STRING[bidx];
      end
      OWN_META: begin
        src_ok   = meta_valid;
        src_byte = meta_data;
      end
      OWN_DATA: begin
        src_ok   = (bidx != 2'd0) || data_valid;
        src_byte = sample_byte;
      end
      default: begin
        src_ok   = 1'b0;
        src_byte = 8'h00;
      end
    endcase
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    id_pending_next = id_pending | send_id;
    last_flag_next  = last_flag;
    bidx_clear      = 1'b0;
    bidx_incr       = 1'b0;
    word_load       = 1'b0;
    tx_start        = 1'b0;
    tx_data         = 8'h00;
    meta_ready      = 1'b0;
    data_ready      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // send_id is looked at directly so a request arriving this cycle wins.
        if (id_pending || send_id) begin
          grant_next      = OWN_ID;
          id_pending_next = 1'b0;
          bidx_clear      = 1'b1;
          state_next      = ST_ISSUE;
        end else if (meta_valid) begin
          grant_next = OWN_META;
          bidx_clear = 1'b1;
          state_next = ST_ISSUE;
        end else if (data_valid) begin
          grant_next = OWN_DATA;
          bidx_clear = 1'b1;
          state_next = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (!tx_busy && src_ok) begin
          tx_start   = 1'b1;
          tx_data    = src_byte;
          state_next = ST_GUARD;
          if (grant == OWN_META) begin
            meta_ready     = 1'b1;
            last_flag_next = meta_last;
          end else if (grant == OWN_DATA && bidx == 2'd0) begin
            data_ready     = 1'b1;
            word_load      = 1'b1;
            last_flag_next = data_last;
          end
        end
      end

      // One cycle for the UART to raise tx_busy after tx_start.
      ST_GUARD: begin
        state_next = ST_DRAIN;
      end

      ST_DRAIN: begin
        if (!tx_busy) begin
          unique case (grant)
            OWN_ID: begin
              if (bidx != ID_LAST) begin
                bidx_incr  = 1'b1;
                state_next = ST_ISSUE;
              end else begin
                grant_next = OWN_NONE;
                state_next = ST_IDLE;
              end
            end
            OWN_META: begin
              if (last_flag) begin
                grant_next = OWN_NONE;
                state_next = ST_IDLE;
              end else begin
                state_next = ST_ISSUE;
              end
            end
            OWN_DATA: begin
              if (bidx != DATA_LAST_BIDX) begin
                bidx_incr  = 1'b1;
                state_next = ST_ISSUE;
              end else begin
                bidx_clear = 1'b1;
                if (last_flag) begin
                  grant_next = OWN_NONE;
                  state_next = ST_IDLE;
                end else begin
                  state_next = ST_ISSUE;
                end
              end
            end
            default: begin
              grant_next = OWN_NONE;
              state_next = ST_IDLE;
            end
          endcase
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A clearing cycle must not hand a byte to the UART or consume a source
    // byte, since the arbiter forgets the packet on this edge.
    if (!soft_reset_n) begin
      tx_start   = 1'b0;
      tx_data    = 8'h00;
      meta_ready = 1'b0;
      data_ready = 1'b0;
      word_load  = 1'b0;
    end
  end

  assign owner = grant;
  assign busy  = (grant != OWN_NONE) || id_pending;

endmodule
`default_nettype wire
